// File: rtl/regfile_dualwr_if.sv
// Decode/writeback bus for the dual-write-port register file.
// The master drives the addresses, write data and enables; the slave returns the read data and the PC.
interface regfile_dualwr_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [WIDTH-1:0]  Y0;
  logic [WIDTH-1:0]  Y1;
  logic [WIDTH-1:0]  I0;
  logic [ADDR_W-1:0] Rc0;
  logic              LE0;
  logic [WIDTH-1:0]  I1;
  logic [ADDR_W-1:0] Rc1;
  logic              LE1;
  logic              pc_inc;
  logic [WIDTH-1:0]  pc_out;

  modport master (
    output Ra, Rb, I0, Rc0, LE0, I1, Rc1, LE1, pc_inc,
    input  Y0, Y1, pc_out
  );

  modport slave (
    input  Ra, Rb, I0, Rc0, LE0, I1, Rc1, LE1, pc_inc,
    output Y0, Y1, pc_out
  );
endinterface

// File: rtl/regfile_dualwr.sv
// WIDTH x DEPTH register file: two combinational read ports, two write ports (port 1 wins on a
// same-address write), an optional write-to-read bypass and an auto-incrementing PC register.
module regfile_dualwr #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned PC_IDX  = 15,
  parameter int unsigned PC_STEP = 4
) (
  input logic              clk,
  input logic              clr,
  regfile_dualwr_if.slave  bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_we0;
  logic             w_we1;
  logic [WIDTH-1:0] w_y0;
  logic [WIDTH-1:0] w_y1;

  // A write only counts when it is enabled and lands inside the array.
  assign w_we0 = !bus.LE0 && (32'(bus.Rc0) < DEPTH);
  assign w_we1 = !bus.LE1 && (32'(bus.Rc1) < DEPTH);

  // Per-register update: reset, then port 1, then port 0, then the PC increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!clr) begin
        r_mem[i] <= '0;
      end else if (w_we1 && (bus.Rc1 == ADDR_W'(i))) begin
        r_mem[i] <= bus.I1;
      end else if (w_we0 && (bus.Rc0 == ADDR_W'(i))) begin
        r_mem[i] <= bus.I0;
      end else if ((i == int'(PC_IDX)) && bus.pc_inc) begin
        r_mem[i] <= r_mem[i] + WIDTH'(PC_STEP);
      end
    end
  end

  // Read muxes; out-of-range addresses match no entry and read 0.
  always_comb begin
    w_y0 = '0;
    w_y1 = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.Ra == ADDR_W'(i)) w_y0 = r_mem[i];
      if (bus.Rb == ADDR_W'(i)) w_y1 = r_mem[i];
    end
    if ((BYPASS != 0) && clr) begin
      if (w_we0 && (bus.Rc0 == bus.Ra)) w_y0 = bus.I0;
      if (w_we1 && (bus.Rc1 == bus.Ra)) w_y0 = bus.I1;
      if (w_we0 && (bus.Rc0 == bus.Rb)) w_y1 = bus.I0;
      if (w_we1 && (bus.Rc1 == bus.Rb)) w_y1 = bus.I1;
    end
  end

  assign bus.Y0     = w_y0;
  assign bus.Y1     = w_y1;
  assign bus.pc_out = r_mem[PC_IDX];

endmodule
